// File: rtl/btb_update_ctrl.sv
// BTB write-side controller: mispredict detection, registered redirect, coalescing update FIFO.
// Optional BTB_STATS_EN adds saturating stat_cti / stat_mispred counters.
module btb_update_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_is_cti,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_hit,
  input  logic [32:0] ex_pred_target,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        upd_valid,
  input  logic        upd_ready,
  output logic [31:0] upd_pc,
  output logic [32:0] upd_target
`ifdef BTB_STATS_EN
  ,
  output logic [31:0] stat_cti,
  output logic [31:0] stat_mispred
`endif
);

  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [31:0]      fifo_pc  [DEPTH];
  logic [32:0]      fifo_tgt [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [PTR_W:0]   count;

  logic [31:0] pc_plus4;
  logic        pred_taken;
  logic [31:0] pred_npc;
  logic [31:0] act_npc;
  logic        mispredict;
  logic        accept;
  logic        enq;
  logic        pop;
  logic        coalesce;
  logic        push;

  always_comb begin
    pc_plus4   = ex_pc + 32'd4;
    pred_taken = ex_pred_hit && ex_pred_target[32];
    pred_npc   = pred_taken ? ex_pred_target[31:0] : pc_plus4;
    act_npc    = ex_taken ? ex_target : pc_plus4;
    mispredict = ex_is_cti && (pred_npc != act_npc);
  end

  assign ex_ready  = (count != CNT_FULL);
  assign upd_valid = (count != '0);
  assign upd_pc     = upd_valid ? fifo_pc[rd_ptr]  : '0;
  assign upd_target = upd_valid ? fifo_tgt[rd_ptr] : '0;

  // Coalescing is suppressed when the tail is also the head being popped
  // this cycle; the update is then pushed as a fresh entry instead.
  always_comb begin
    accept   = ex_valid && ex_ready;
    enq      = accept && mispredict && (ex_taken || ex_pred_hit);
    pop      = upd_valid && upd_ready;
    tail_ptr = wr_ptr - PTR_ONE;
    coalesce = enq && (count != '0) && (fifo_pc[tail_ptr] == ex_pc)
               && !((count == CNT_ONE) && pop);
    push     = enq && !coalesce;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]  <= ex_pc;
      fifo_tgt[wr_ptr] <= {ex_taken, act_npc};
    end else if (coalesce) begin
      fifo_tgt[tail_ptr] <= {ex_taken, act_npc};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= accept && mispredict;
      if (accept && mispredict) redirect_pc <= act_npc;
    end
  end

`ifdef BTB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_cti     <= '0;
      stat_mispred <= '0;
    end else begin
      if (accept && ex_is_cti && (stat_cti != '1))
        stat_cti <= stat_cti + 32'd1;
      if (accept && mispredict && (stat_mispred != '1))
        stat_mispred <= stat_mispred + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Self-checking bench for btb_update_ctrl: directed scenarios plus randomized
// traffic checked against a queue-based reference model.
module tb_btb_update_ctrl;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic        ex_is_cti;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_hit;
  logic [32:0] ex_pred_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic        upd_ready;
  logic [31:0] upd_pc;
  logic [32:0] upd_target;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mq_pc[$];
  logic [32:0] mq_tgt[$];
  logic        m_rv;
  logic [31:0] m_rpc;

  btb_update_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_is_cti(ex_is_cti),
    .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_hit(ex_pred_hit), .ex_pred_target(ex_pred_target),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_pc(upd_pc), .upd_target(upd_target)
  );

  always #5 clk = ~clk;

  // Reference: next-PC comparison, then an in-order queue of BTB writes
  // where a repeat PC at the newest slot replaces that slot's target.
  task automatic model_update();
    logic [31:0] seq_pc, pred_pc, real_pc;
    logic acc, mis, do_pop;
    int n;
    if (!rst) begin
      mq_pc.delete(); mq_tgt.delete(); m_rv = 0; m_rpc = 0;
      return;
    end
    seq_pc  = ex_pc + 32'd4;
    pred_pc = (ex_pred_hit && ex_pred_target[32]) ? ex_pred_target[31:0] : seq_pc;
    real_pc = ex_taken ? ex_target : seq_pc;
    n       = mq_pc.size();
    acc     = ex_valid && (n < DEPTH);
    mis     = ex_is_cti && (pred_pc != real_pc);
    do_pop  = (n > 0) && upd_ready;
    if (do_pop) begin
      void'(mq_pc.pop_front());
      void'(mq_tgt.pop_front());
    end
    if (acc && mis && (ex_taken || ex_pred_hit)) begin
      if (n > 0 && !(n == 1 && do_pop) && mq_pc[$] == ex_pc)
        mq_tgt[$] = {ex_taken, real_pc};
      else begin
        mq_pc.push_back(ex_pc);
        mq_tgt.push_back({ex_taken, real_pc});
      end
    end
    m_rv = acc && mis;
    if (acc && mis) m_rpc = real_pc;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input logic v, input logic cti, input logic [31:0] pc,
                       input logic tk, input logic [31:0] tgt,
                       input logic hit, input logic [32:0] ptgt);
    ex_valid = v; ex_is_cti = cti; ex_pc = pc; ex_taken = tk;
    ex_target = tgt; ex_pred_hit = hit; ex_pred_target = ptgt;
  endtask

  task automatic idle();
    drive(0, 0, 32'h0, 0, 32'h0, 0, 33'h0);
  endtask

  task automatic test_reset();
    idle(); upd_ready = 0; rst = 0;
    model_update();
    #12;
    checks++;
    if (ex_ready !== 1'b1 || upd_valid !== 1'b0 || redirect_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: ex_ready=%b upd_valid=%b redirect_valid=%b required 1 0 0",
               ex_ready, upd_valid, redirect_valid);
    end
    checks++;
    if (upd_pc !== 32'h0 || upd_target !== 33'h0 || redirect_pc !== 32'h0) begin
      failures++;
      $display("FAIL reset_data: upd_pc=%h upd_target=%h redirect_pc=%h required 0 0 0",
               upd_pc, upd_target, redirect_pc);
    end
    @(negedge clk); rst = 1;
    #4;
  endtask

  task automatic test_correct_pred();
    upd_ready = 1;
    drive(1, 1, 32'h100, 1, 32'h200, 1, {1'b1, 32'h200});
    tick(); idle();
    checks++;
    if (redirect_valid !== 1'b0 || upd_valid !== 1'b0) begin
      failures++;
      $display("FAIL correct_pred: redirect_valid=%b upd_valid=%b required 0 0",
               redirect_valid, upd_valid);
    end
    tick();
    checks++;
    if (upd_valid !== 1'b0) begin
      failures++;
      $display("FAIL correct_pred_later: upd_valid=%b required 0", upd_valid);
    end
  endtask

  task automatic test_taken_miss();
    upd_ready = 1;
    drive(1, 1, 32'h100, 1, 32'h180, 0, 33'h0);
    tick(); idle();
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h180) begin
      failures++;
      $display("FAIL taken_miss_redirect: valid=%b pc=%h required 1 00000180",
               redirect_valid, redirect_pc);
    end
    checks++;
    if (upd_valid !== 1'b1 || upd_pc !== 32'h100 || upd_target !== {1'b1, 32'h180}) begin
      failures++;
      $display("FAIL taken_miss_upd: valid=%b pc=%h target=%h required 1 00000100 100000180",
               upd_valid, upd_pc, upd_target);
    end
    tick();
    checks++;
    if (upd_valid !== 1'b0 || redirect_valid !== 1'b0) begin
      failures++;
      $display("FAIL taken_miss_after: upd_valid=%b redirect_valid=%b required 0 0",
               upd_valid, redirect_valid);
    end
  endtask

  task automatic test_stale_entry();
    upd_ready = 0;
    drive(1, 1, 32'h40, 0, 32'h999, 1, {1'b1, 32'h80});
    tick(); idle();
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h44) begin
      failures++;
      $display("FAIL stale_redirect: valid=%b pc=%h required 1 00000044",
               redirect_valid, redirect_pc);
    end
    checks++;
    if (upd_valid !== 1'b1 || upd_pc !== 32'h40 || upd_target !== {1'b0, 32'h44}) begin
      failures++;
      $display("FAIL stale_upd: valid=%b pc=%h target=%h required 1 00000040 000000044",
               upd_valid, upd_pc, upd_target);
    end
    upd_ready = 1;
    tick();
  endtask

  task automatic test_no_entry_not_taken();
    upd_ready = 0;
    drive(1, 1, 32'h300, 0, 32'h500, 0, 33'h0);
    tick();
    drive(1, 0, 32'h310, 1, 32'h700, 0, 33'h0);
    tick(); idle();
    checks++;
    if (upd_valid !== 1'b0 || redirect_valid !== 1'b0) begin
      failures++;
      $display("FAIL no_write_cases: upd_valid=%b redirect_valid=%b required 0 0",
               upd_valid, redirect_valid);
    end
  endtask

  task automatic test_full_wrap();
    upd_ready = 0;
    for (int i = 1; i <= 4; i++) begin
      drive(1, 1, 32'(i * 16), 1, 32'(i * 16 + 32'h1000), 0, 33'h0);
      tick();
    end
    idle();
    checks++;
    if (ex_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_ready: ex_ready=%b required 0", ex_ready);
    end
    drive(1, 1, 32'h50, 1, 32'h2000, 0, 33'h0);
    tick(); idle();
    checks++;
    if (redirect_valid !== 1'b0 || upd_pc !== 32'h10) begin
      failures++;
      $display("FAIL full_blocked: redirect_valid=%b head=%h required 0 00000010",
               redirect_valid, upd_pc);
    end
    upd_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (upd_valid !== 1'b1 || upd_pc !== 32'(i * 16)
          || upd_target !== {1'b1, 32'(i * 16 + 32'h1000)}) begin
        failures++;
        $display("FAIL drain_order[%0d]: valid=%b pc=%h target=%h required 1 %h %h",
                 i, upd_valid, upd_pc, upd_target, 32'(i * 16),
                 {1'b1, 32'(i * 16 + 32'h1000)});
      end
      tick();
      if (i == 1) begin
        checks++;
        if (ex_ready !== 1'b1) begin
          failures++;
          $display("FAIL ready_after_pop: ex_ready=%b required 1", ex_ready);
        end
      end
    end
    checks++;
    if (upd_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain_empty: upd_valid=%b required 0", upd_valid);
    end
  endtask

  task automatic test_coalesce();
    upd_ready = 0;
    drive(1, 1, 32'h100, 1, 32'h200, 0, 33'h0);
    tick();
    drive(1, 1, 32'h100, 1, 32'h300, 0, 33'h0);
    tick(); idle();
    checks++;
    if (upd_valid !== 1'b1 || upd_pc !== 32'h100 || upd_target !== {1'b1, 32'h300}) begin
      failures++;
      $display("FAIL coalesce_head: valid=%b pc=%h target=%h required 1 00000100 100000300",
               upd_valid, upd_pc, upd_target);
    end
    upd_ready = 1;
    tick();
    checks++;
    if (upd_valid !== 1'b0) begin
      failures++;
      $display("FAIL coalesce_count: upd_valid=%b after one pop, required 0", upd_valid);
    end
  endtask

  task automatic test_random();
    logic [31:0] pcs [4];
    logic [31:0] p;
    pcs[0] = 32'h1000; pcs[1] = 32'h1004; pcs[2] = 32'h2000; pcs[3] = 32'hFFFF_FFFC;
    for (int c = 0; c < 600; c++) begin
      p = pcs[$urandom_range(0, 3)];
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0, p,
            1'($urandom_range(0, 1)), p + 32'(16 * $urandom_range(0, 3)),
            1'($urandom_range(0, 1)),
            {1'($urandom_range(0, 1)), p + 32'(16 * $urandom_range(0, 3))});
      upd_ready = ($urandom_range(0, 2) == 0);
      tick();
      checks++;
      if (ex_ready !== (mq_pc.size() != DEPTH) || upd_valid !== (mq_pc.size() != 0)) begin
        failures++;
        $display("FAIL rnd_flags[%0d]: ex_ready=%b upd_valid=%b required %b %b",
                 c, ex_ready, upd_valid, mq_pc.size() != DEPTH, mq_pc.size() != 0);
      end
      if (mq_pc.size() != 0) begin
        checks++;
        if (upd_pc !== mq_pc[0] || upd_target !== mq_tgt[0]) begin
          failures++;
          $display("FAIL rnd_head[%0d]: pc=%h target=%h required %h %h",
                   c, upd_pc, upd_target, mq_pc[0], mq_tgt[0]);
        end
      end
      checks++;
      if (redirect_valid !== m_rv || (m_rv && redirect_pc !== m_rpc)) begin
        failures++;
        $display("FAIL rnd_redirect[%0d]: valid=%b pc=%h required %b %h",
                 c, redirect_valid, redirect_pc, m_rv, m_rpc);
      end
    end
    idle(); upd_ready = 1;
    for (int i = 0; i < DEPTH + 1; i++) tick();
  endtask

  task automatic test_async_reset();
    upd_ready = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 32'(32'h400 + i * 8), 1, 32'h800, 0, 33'h0);
      tick();
    end
    idle();
    #2;
    rst = 0;
    model_update();
    #1;
    checks++;
    if (upd_valid !== 1'b0 || redirect_valid !== 1'b0 || ex_ready !== 1'b1) begin
      failures++;
      $display("FAIL async_reset: upd_valid=%b redirect_valid=%b ex_ready=%b required 0 0 1",
               upd_valid, redirect_valid, ex_ready);
    end
    @(negedge clk); rst = 1;
    upd_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (upd_valid !== 1'b0 || redirect_valid !== 1'b0) begin
        failures++;
        $display("FAIL post_reset[%0d]: upd_valid=%b redirect_valid=%b required 0 0",
                 i, upd_valid, redirect_valid);
      end
    end
  endtask

  initial begin
    m_rv = 0; m_rpc = 0;
    test_reset();
    test_correct_pred();
    test_taken_miss();
    test_stale_entry();
    test_no_entry_not_taken();
    test_full_wrap();
    test_coalesce();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/btb_update_ctrl.md
Name: btb_update_ctrl

Overview:
- Write-side controller for the branch target buffer. It sits between the execute stage and the BTB update port.
- For every resolved control-transfer instruction, it compares the fetch-time prediction with the actual outcome and raises a registered redirect on a mispredict.
- Required BTB writes are queued in a small coalescing FIFO and drained one per cycle into the BTB's valid_in/branch_PC/branch_target port.

Parameters:
- DEPTH, 4, update FIFO entries; power of two, at least 2.
- PTR_W, $clog2(DEPTH), FIFO pointer width; count register is PTR_W+1 bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- ex_valid  in  1  execute stage presents a resolved instruction.
- ex_ready  out  1  controller can accept; transfer = ex_valid && ex_ready.
- ex_is_cti  in  1  instruction is a branch/jump; if 0, the transfer is ignored.
- ex_pc  in  32  PC of the instruction.
- ex_taken  in  1  actual direction.
- ex_target  in  32  actual taken target.
- ex_pred_hit  in  1  BTB hit flag carried from fetch.
- ex_pred_target  in  33  BTB target carried from fetch; bit32 = predicted-taken, [31:0] = address.
- redirect_valid  out  1  one-cycle pulse: front end must refetch.
- redirect_pc  out  32  correct next PC; valid while redirect_valid=1.
- upd_valid  out  1  FIFO head present; drives BTB valid_in.
- upd_ready  in  1  BTB write slot available this cycle.
- upd_pc  out  32  head PC; drives BTB branch_PC.
- upd_target  out  33  head {taken, target}; drives BTB branch_target.

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO empty (rd/wr pointers 0, count 0).
  - ex_ready=1, upd_valid=0, upd_pc=0, upd_target=0, redirect_valid=0, redirect_pc=0.
  - Reset mid-operation discards all queued updates and any pending redirect.
- Prediction arithmetic (32-bit, wraps modulo 2^32):
  - pred_taken = ex_pred_hit && ex_pred_target[32].
  - pred_npc = pred_taken ? ex_pred_target[31:0] : ex_pc+4.
  - act_npc = ex_taken ? ex_target : ex_pc+4.
  - mispredict = ex_is_cti && (pred_npc != act_npc).
- Redirect (latency 1):
  - On an accepted transfer with mispredict=1, the next cycle has redirect_valid=1 and redirect_pc=act_npc.
  - redirect_valid is otherwise 0, and it never lasts more than one cycle per transfer.
- Update entry: {pc=ex_pc, target={ex_taken, act target}}, where act target = ex_target if taken, else ex_pc+4.
- Enqueue rule: enqueue on an accepted transfer when mispredict && (ex_taken || ex_pred_hit).
  - A not-taken branch with no BTB entry is never written.
- Coalescing:
  - If FIFO is non-empty and the newest (tail) entry has pc == ex_pc, that entry's target is overwritten in place; count is unchanged.
  - If the tail is being popped in that same cycle (count==1 and pop), a normal push is done instead.
- Flow control:
  - ex_ready = (count != DEPTH), registered-state only; no combinational path from upd_ready.
  - Transfers whose ex_valid && ex_ready is false have no effect.
- Drain:
  - upd_valid = (count != 0); upd_pc and upd_target show the head entry.
  - Pop on upd_valid && upd_ready.
  - A push into an empty FIFO is visible on upd_* the next cycle; there is no bypass.
- Simultaneous push and pop: count is unchanged and both pointers advance, including when count==DEPTH-1.
- Wrap-around: pointers wrap modulo DEPTH.
- Full: when count==DEPTH, ex_ready=0, so push and coalesce cannot occur.
- Ordering: updates leave in acceptance order. A later entry for the same PC that is not at the tail is queued separately; the BTB overwrites in order.

Optional Feature:
- BTB_STATS_EN defined: adds outputs stat_cti[31:0] and stat_mispred[31:0], both reset to 0.
  - stat_cti increments on each accepted transfer with ex_is_cti=1.
  - stat_mispred increments on each accepted mispredict.
  - Both saturate at 32'hFFFFFFFF.
- BTB_STATS_EN undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Correct prediction: ex_pc=0x100, taken, target 0x200, pred_hit=1, pred_target={1,0x200} -> no redirect, no enqueue, upd_valid stays 0.
- Taken miss with upd_ready=1: ex_pc=0x100, taken, target 0x180, pred_hit=0.
  - Next cycle: redirect_valid=1, redirect_pc=0x180, upd_valid=1, upd_pc=0x100, upd_target={1,0x180}.
  - The cycle after: upd_valid=0.
- Stale entry: ex_pc=0x40, not taken, pred_hit=1, pred_target={1,0x80} -> redirect_pc=0x44, enqueued target={0,0x44}.
- Full/wrap: upd_ready=0, 4 distinct-PC mispredicts (0x10, 0x20, 0x30, 0x40) -> ex_ready=0 after the 4th.
  - Raise upd_ready -> entries drain in order 0x10, 0x20, 0x30, 0x40, one per cycle, and ex_ready=1 after the first pop.
- Coalesce: upd_ready=0, mispredicts for pc=0x100 with target 0x200, then again pc=0x100 with target 0x300 -> count=1, head target={1,0x300}.
- Async reset mid-drain: assert rst=0 with 3 entries queued -> upd_valid=0 and redirect_valid=0 immediately, without waiting for a clock edge, and no further updates after release.
